// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Source-class codes, the "source unused" Tuse marker and the table entry layout.
// Default field widths match the top-level parameter defaults.
package hazard_scoreboard_pkg;

    localparam int SB_AW = 5;
    localparam int SB_TW = 2;
    localparam int SB_SW = 2;

    // Forward-source classes: which unit produces the pending result
    localparam logic [SB_SW-1:0] SRC_PC  = 2'd0;
    localparam logic [SB_SW-1:0] SRC_ALU = 2'd1;
    localparam logic [SB_SW-1:0] SRC_EXT = 2'd2;
    localparam logic [SB_SW-1:0] SRC_DM  = 2'd3;

    // All-ones Tuse marks a source operand that the instruction does not read
    localparam logic [SB_TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] a3;
        logic [SB_TW-1:0] tnew;
        logic [SB_SW-1:0] src;
    } entry_t;

    // One pipeline step closer to the result being available; never below zero
    function automatic logic [SB_TW-1:0] tnew_dec(input logic [SB_TW-1:0] t);
        return (t == '0) ? t : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the hazard scoreboard.
// Outputs are combinational from the id_* fields and the scoreboard table.
// stall is the only backpressure: decode holds its instruction while it is high.
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int TW = 2,
    parameter int SW = 2
);
    logic          id_valid;
    logic [AW-1:0] id_a1;
    logic [AW-1:0] id_a2;
    logic [TW-1:0] id_tuse1;
    logic [TW-1:0] id_tuse2;
    logic [AW-1:0] id_a3;
    logic [TW-1:0] id_tnew;
    logic [SW-1:0] id_src;
    logic          flush;
    logic          stall;
    logic [3:0]    fwd_sel1;
    logic [3:0]    fwd_sel2;
    logic [SW-1:0] fwd_src1;
    logic [SW-1:0] fwd_src2;

    modport master (
        output id_valid, id_a1, id_a2, id_tuse1, id_tuse2, id_a3, id_tnew, id_src, flush,
        input  stall, fwd_sel1, fwd_sel2, fwd_src1, fwd_src2
    );

    modport slave (
        input  id_valid, id_a1, id_a2, id_tuse1, id_tuse2, id_a3, id_tnew, id_src, flush,
        output stall, fwd_sel1, fwd_sel2, fwd_src1, fwd_src2
    );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Per-read-port youngest-producer search plus Tnew-versus-Tuse hazard compare.
// Purely combinational, zero cycles.
// No handshake; hazard feeds the scoreboard stall term.
module scoreboard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3
) (
    input  entry_t [NSTAGE-1:0] tbl,
    input  logic [SB_AW-1:0]    id_a,
    input  logic [SB_TW-1:0]    id_tuse,
    output logic [3:0]          sel,
    output logic [SB_SW-1:0]    src,
    output logic                hazard
);

    // Scan oldest to youngest so the youngest hit is the last write and wins
    always_comb begin
        sel    = 4'd0;
        src    = '0;
        hazard = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (tbl[k].valid && (tbl[k].a3 == id_a) && (id_a != '0)) begin
                sel    = 4'(k + 1);
                src    = tbl[k].src;
                hazard = (id_tuse != TUSE_NONE) && (tbl[k].tnew > id_tuse);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations, picks forwarding stages and raises decode stall.
// Forward/stall outputs are combinational; the table advances one stage per clock.
// Stall holds decode and injects a bubble; HAZARD_SCOREBOARD_STATS_EN adds stall_cnt.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int AW     = SB_AW,
    parameter int TW     = SB_TW,
    parameter int SW     = SB_SW
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  sb
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    entry_t [NSTAGE-1:0] tbl_q;
    entry_t [NSTAGE-1:0] tbl_d;
    logic                hazard1;
    logic                hazard2;
    logic                stall;

    scoreboard_match #(.NSTAGE(NSTAGE)) u_match1 (
        .tbl     (tbl_q),
        .id_a    (sb.id_a1),
        .id_tuse (sb.id_tuse1),
        .sel     (sb.fwd_sel1),
        .src     (sb.fwd_src1),
        .hazard  (hazard1)
    );

    scoreboard_match #(.NSTAGE(NSTAGE)) u_match2 (
        .tbl     (tbl_q),
        .id_a    (sb.id_a2),
        .id_tuse (sb.id_tuse2),
        .sel     (sb.fwd_sel2),
        .src     (sb.fwd_src2),
        .hazard  (hazard2)
    );

    // A bubble in decode never stalls, whatever its operand fields hold
    assign stall    = sb.id_valid & (hazard1 | hazard2);
    assign sb.stall = stall;

    // Next table: flush empties it, otherwise shift with Tnew ageing and insert at stage 1
    always_comb begin
        tbl_d = tbl_q;
        if (sb.flush) begin
            tbl_d = '0;
        end else begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                tbl_d[k]      = tbl_q[k-1];
                tbl_d[k].tnew = tnew_dec(tbl_q[k-1].tnew);
            end
            if (stall) begin
                tbl_d[0] = '0;
            end else begin
                tbl_d[0].valid = sb.id_valid & (sb.id_a3 != '0);
                tbl_d[0].a3    = sb.id_a3;
                tbl_d[0].tnew  = sb.id_tnew;
                tbl_d[0].src   = sb.id_src;
            end
        end
    end

    // Table register; reset empties it without waiting for a clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_q <= '0;
        end else begin
            tbl_q <= tbl_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Count cycles lost to stalls; a flushed cycle is not counted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !sb.flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register, wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard: forwarding selection, stalls, flush, reset.
// Inputs change 1 ns after the rising edge; outputs are sampled 1-3 ns later.
// Build with HAZARD_SCOREBOARD_STATS_EN to also check the stall counter.
module tb_hazard_scoreboard;

    localparam logic [1:0] NONE = 2'b11;
    localparam logic [1:0] ALU  = 2'd1;
    localparam logic [1:0] EXT  = 2'd2;
    localparam logic [1:0] DM   = 2'd3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    hazard_scoreboard_if #(.AW(5), .TW(2), .SW(2)) sb_if ();

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    hazard_scoreboard #(.NSTAGE(3), .AW(5), .TW(2), .SW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .sb        (sb_if.slave)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a3, input logic [1:0] tnew,
                         input logic [1:0] src, input logic [4:0] a1, input logic [1:0] t1,
                         input logic [4:0] a2, input logic [1:0] t2);
        sb_if.id_valid = v;
        sb_if.id_a3    = a3;
        sb_if.id_tnew  = tnew;
        sb_if.id_src   = src;
        sb_if.id_a1    = a1;
        sb_if.id_tuse1 = t1;
        sb_if.id_a2    = a2;
        sb_if.id_tuse2 = t2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic st, input logic [3:0] s1,
                             input logic [1:0] r1, input logic [3:0] s2, input logic [1:0] r2);
        check({tag, "_stall"}, 32'(sb_if.stall), 32'(st));
        check({tag, "_sel1"},  32'(sb_if.fwd_sel1), 32'(s1));
        check({tag, "_src1"},  32'(sb_if.fwd_src1), 32'(r1));
        check({tag, "_sel2"},  32'(sb_if.fwd_sel2), 32'(s2));
        check({tag, "_src2"},  32'(sb_if.fwd_src2), 32'(r2));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        sb_if.flush = 1'b0;
        drive(1'b1, 5'd8, 2'd2, DM, 5'd8, 2'd0, 5'd9, 2'd0);
        #2;
        check_out("reset", 1'b0, 4'd0, 2'd0, 4'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("reset_cnt", stall_cnt, 32'd0);
`endif
        #10;
        reset = 1'b0;
        tick();

        // Scenario 1: lw $8 (tnew 2, DM) then addu reading $8 with tuse 0
        drive(1'b1, 5'd8, 2'd2, DM, 5'd0, NONE, 5'd0, NONE);
        #1 check_out("s1_lw", 1'b0, 4'd0, 2'd0, 4'd0, 2'd0);
        tick();
        drive(1'b1, 5'd10, 2'd1, ALU, 5'd8, 2'd0, 5'd0, NONE);
        #1 check_out("s1_c0", 1'b1, 4'd1, DM, 4'd0, 2'd0);
        tick();
        #1 check_out("s1_c1", 1'b1, 4'd2, DM, 4'd0, 2'd0);
        tick();
        #1 check_out("s1_c2", 1'b0, 4'd3, DM, 4'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("s1_cnt", stall_cnt, 32'd2);
`endif
        tick();

        // Scenario 2: ori $9 (tnew 1, ALU) while port 2 reads $10 from the addu
        drive(1'b1, 5'd9, 2'd1, ALU, 5'd0, NONE, 5'd10, 2'd1);
        #1 check_out("s2_ori", 1'b0, 4'd0, 2'd0, 4'd1, ALU);
        tick();
        drive(1'b1, 5'd5, 2'd0, EXT, 5'd9, 2'd1, 5'd10, 2'd0);
        #1 check_out("s2_use", 1'b0, 4'd1, ALU, 4'd2, ALU);
        tick();

        // Scenario 3: $5 in stage 1 (ALU, tnew 1) and stage 2 (EXT)
        drive(1'b1, 5'd5, 2'd1, ALU, 5'd0, NONE, 5'd0, NONE);
        tick();
        drive(1'b1, 5'd0, 2'd0, ALU, 5'd5, 2'd1, 5'd5, NONE);
        #1 check_out("s3_young", 1'b0, 4'd1, ALU, 4'd1, ALU);
        drive(1'b1, 5'd0, 2'd0, ALU, 5'd5, 2'd0, 5'd0, NONE);
        #1 check_out("s3_stall", 1'b1, 4'd1, ALU, 4'd0, 2'd0);
        drive(1'b0, 5'd0, 2'd0, ALU, 5'd5, 2'd0, 5'd0, NONE);
        #1 check_out("s3_bubble", 1'b0, 4'd1, ALU, 4'd0, 2'd0);

        // Scenario 4: destination $0 with tnew 3 is never tracked
        drive(1'b1, 5'd0, 2'd3, DM, 5'd0, NONE, 5'd0, NONE);
        tick();
        drive(1'b1, 5'd0, 2'd0, ALU, 5'd0, 2'd0, 5'd0, 2'd0);
        #1 check_out("s4_r0", 1'b0, 4'd0, 2'd0, 4'd0, 2'd0);
        drive(1'b1, 5'd0, 2'd0, ALU, 5'd5, 2'd0, 5'd0, 2'd0);
        #1 check_out("s4_age", 1'b0, 4'd2, ALU, 4'd0, 2'd0);

        // Scenario 5: stall on lw $7 then flush in the stalled cycle
        drive(1'b1, 5'd7, 2'd3, DM, 5'd0, NONE, 5'd0, NONE);
        tick();
        drive(1'b1, 5'd11, 2'd1, ALU, 5'd7, 2'd0, 5'd5, 2'd1);
        #1 check_out("s5_pre", 1'b1, 4'd1, DM, 4'd3, ALU);
        sb_if.flush = 1'b1;
        tick();
        sb_if.flush = 1'b0;
        #1 check_out("s5_post", 1'b0, 4'd0, 2'd0, 4'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("s5_cnt", stall_cnt, 32'd2);
`endif

        // Scenario 6: reset between edges while stalled
        drive(1'b1, 5'd7, 2'd3, DM, 5'd0, NONE, 5'd0, NONE);
        tick();
        drive(1'b1, 5'd11, 2'd1, ALU, 5'd7, 2'd0, 5'd0, NONE);
        tick();
        #1 check_out("s6_pre", 1'b1, 4'd2, DM, 4'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("s6_cnt_pre", stall_cnt, 32'd3);
`endif
        #1 reset = 1'b1;
        #1 check_out("s6_rst", 1'b0, 4'd0, 2'd0, 4'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        check("s6_cnt", stall_cnt, 32'd0);
`endif
        tick();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NSTAGE, 3, number of tracked stages after decode (E, M, W, ...); legal range 1..8.
REQ-002 Parameter AW, 5, register address width.
REQ-003 Parameter TW, 2, width of Tuse/Tnew fields.
REQ-004 Parameter SW, 2, width of the forward-source class (PC, ALUOut, EXTOut, DMOut).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 id_valid  in  1  decode-stage instruction is real (not a bubble).
REQ-008 id_a1 / id_a2  in  AW  source registers read in decode.
REQ-009 id_tuse1 / id_tuse2  in  TW  cycles until each source is consumed; all-ones means the source is unused.
REQ-010 id_a3  in  AW  destination register of the decode instruction.
REQ-011 id_tnew  in  TW  cycles until the result exists, counted from entry into stage 1.
REQ-012 id_src  in  SW  class of unit producing the result.
REQ-013 flush  in  1  invalidate all tracked entries.
REQ-014 stall  out  1  freeze fetch/decode and insert a bubble.
REQ-015 fwd_sel1 / fwd_sel2  out  4  0 = register file, k = stage k (1..NSTAGE).
REQ-016 fwd_src1 / fwd_src2  out  SW  source class of the selected stage entry; 0 when fwd_sel = 0.

Function
REQ-017 Internal table of NSTAGE entries {valid, a3, tnew, src}; entry 1 is youngest.
REQ-018 Port p match: youngest valid entry k with a3 == id_ap and a3 != 0.
REQ-019 If a match exists, fwd_selp = k and fwd_srcp = src[k]; otherwise both are 0.
REQ-020 Match outputs are combinational, with zero-cycle latency from the id_* inputs and table state.
REQ-021 Register 0 never matches, never forwards and never stalls.
REQ-022 stall = id_valid AND, for some used port p with match k, tnew[k] > id_tusep.
REQ-023 A port with id_tusep all-ones never causes a stall.
REQ-024 Each edge without flush: entry k+1 takes entry k with tnew decremented, saturating at 0.
REQ-025 The oldest entry retires on that shift.
REQ-026 Each edge without flush and without stall: entry 1 takes {id_valid & (id_a3 != 0), id_a3, id_tnew, id_src}.
REQ-027 Each edge with stall: entry 1 takes a bubble (valid = 0); the other entries still shift.
REQ-028 Each edge with flush: every entry becomes invalid; flush wins over stall and issue.
REQ-029 During stall, fwd_sel and fwd_src remain valid outputs; consumers ignore them.

Reset
REQ-030 While reset is high, all entries are invalid, tnew is 0 and src is 0.
REQ-031 While reset is high, stall = 0, fwd_sel1 = fwd_sel2 = 0 and fwd_src1 = fwd_src2 = 0.
REQ-032 Reset asserted mid-stall clears the table immediately, with no clock edge needed.

Configuration
REQ-033 Macro HAZARD_SCOREBOARD_STATS_EN, when defined, adds output stall_cnt (32 bits).
REQ-034 stall_cnt increments on each edge where stall = 1 and flush = 0, and wraps at 2^32.
REQ-035 reset clears stall_cnt to 0.
REQ-036 Without the macro, the port and counter do not exist, and the remaining behaviour is identical.

Structure
REQ-037 Shared package holds the source-class constants (PC = 0, ALUOut = 1, EXTOut = 2, DMOut = 3) and the TUSE_NONE constant.
REQ-038 Shared package holds the entry struct typedef.
REQ-039 One sub-module, scoreboard_match, is instantiated once per read port.
REQ-040 scoreboard_match performs the youngest-match priority search and the Tnew compare.

Verification
REQ-041 Scenario 1: issue lw $8 (tnew 2, src DMOut); next cycle addu reads $8 with tuse 0 -> stall = 1 for 2 cycles, then fwd_sel1 = 3, fwd_src1 = DMOut.
REQ-042 Scenario 2: ori $9 (tnew 1, src ALUOut), then consumer tuse 1 -> no stall, fwd_sel = 1, fwd_src = ALUOut.
REQ-043 Scenario 3: $5 written in stages 1 and 2, consumer reads $5 -> fwd_sel selects stage 1 (youngest).
REQ-044 Scenario 4: destination $0 with tnew 3, consumer reads $0 -> stall = 0, fwd_sel = 0.
REQ-045 Scenario 5: stall active, then flush asserted -> next cycle table empty, stall = 0.
REQ-046 Scenario 6: reset asserted between clock edges mid-stall -> outputs 0 at once; stall_cnt = 0 when the macro is defined.
